alu_commit_stage: RTL and testbench

- Downstream of the 20-bit ALU; consumes one ALU result bundle per transaction through a valid/ready handshake.
- Owns the architectural status register, bit layout {C,S,Z} = status_q[2:0].
- Executes LSR and XSR status-register operations and resolves jumps (unconditional, zero, sign, zero-sign) into a one-cycle redirect pulse.
- Drives the register-file write port, sequencing two writes for swap.

---
 rtl/alu_commit_stage.sv | 172 +++++++++++++++++
 tb/tb_alu_commit_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_commit_stage.sv
// Commit stage behind the 20-bit ALU: status register {C,S,Z}, jump resolution, register-file writes.
// Optional: define COMMIT_TRAP_SHADOW_EN to add a trap shadow copy of the status register.
module alu_commit_stage #(
    parameter int DATA_W = 20,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_dst_a,
    input  logic [REG_AW-1:0] in_dst_b,
    input  logic [DATA_W-1:0] in_res_a,
    input  logic [DATA_W-1:0] in_res_b,
    input  logic              in_zero,
    input  logic              in_sign,
    input  logic              in_carry,
    input  logic [2:0]        in_flag_mask,
    input  logic [1:0]        in_jcond,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic [2:0]        status_q,
    output logic              jmp_valid,
    output logic [DATA_W-1:0] jmp_target,
    input  logic              trap_req,
    input  logic              trap_ret
);

    localparam logic [2:0] OP_WR    = 3'd0;
    localparam logic [2:0] OP_SWAP  = 3'd1;
    localparam logic [2:0] OP_FLAGS = 3'd2;
    localparam logic [2:0] OP_JMP   = 3'd3;
    localparam logic [2:0] OP_LSR   = 3'd4;
    localparam logic [2:0] OP_XSR   = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rdy_q;
    logic                accept;
    logic                is_write_op;
    logic                swap_q;
    logic [REG_AW-1:0]   dst_b_q;
    logic [DATA_W-1:0]   res_b_q;
    logic [2:0]          new_flags;
    logic [2:0]          op_status;
    logic [2:0]          status_d;
    logic                jmp_taken;

    // rdy_q keeps in_ready low through reset and releases it one cycle later
    assign in_ready    = rdy_q && (state_q == IDLE);
    assign accept      = in_valid && in_ready;
    assign is_write_op = (in_op == OP_WR) || (in_op == OP_SWAP);
    assign wr_en       = (state_q != IDLE);
    assign new_flags   = {in_carry, in_sign, in_zero};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_write_op) begin
                    state_d = WR_A;
                end
            end
            WR_A: begin
                if (wr_ack) begin
                    state_d = swap_q ? WR_B : IDLE;
                end
            end
            WR_B: begin
                if (wr_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_status = status_q;
        if (accept) begin
            case (in_op)
                OP_WR, OP_SWAP, OP_FLAGS: op_status = (status_q & ~in_flag_mask) | (new_flags & in_flag_mask);
                OP_LSR:                   op_status = in_res_a[2:0];
                OP_XSR:                   op_status = status_q ^ in_res_a[2:0];
                default:                  op_status = status_q;
            endcase
        end
    end

    always_comb begin
        jmp_taken = 1'b0;
        case (in_jcond)
            2'd0: jmp_taken = 1'b1;
            2'd1: jmp_taken = status_q[0];
            2'd2: jmp_taken = status_q[1];
            2'd3: jmp_taken = status_q[0] | status_q[1];
            default: jmp_taken = 1'b0;
        endcase
    end

`ifdef COMMIT_TRAP_SHADOW_EN
    logic [2:0] shadow_q;

    // trap_req captures the pre-edge status; trap_ret overrides any same-edge op update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 3'b000;
        end else if (trap_req) begin
            shadow_q <= status_q;
        end
    end

    assign status_d = trap_ret ? shadow_q : op_status;
`else
    logic unused_trap;
    assign unused_trap = trap_req ^ trap_ret;
    assign status_d    = op_status;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            status_q   <= 3'b000;
            jmp_valid  <= 1'b0;
            jmp_target <= '0;
        end else begin
            rdy_q     <= 1'b1;
            status_q  <= status_d;
            jmp_valid <= accept && (in_op == OP_JMP) && jmp_taken;
            if (accept && (in_op == OP_JMP) && jmp_taken) begin
                jmp_target <= in_res_a;
            end
        end
    end

    // write port registers: loaded with the A write on accept, switched to B when A is acked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_data <= '0;
            swap_q  <= 1'b0;
            dst_b_q <= '0;
            res_b_q <= '0;
        end else if (accept && is_write_op) begin
            wr_addr <= in_dst_a;
            wr_data <= in_res_a;
            swap_q  <= (in_op == OP_SWAP);
            dst_b_q <= in_dst_b;
            res_b_q <= in_res_b;
        end else if ((state_q == WR_A) && wr_ack && swap_q) begin
            wr_addr <= dst_b_q;
            wr_data <= res_b_q;
        end
    end

endmodule

// File: tb/tb_alu_commit_stage.sv
// Self-checking bench for alu_commit_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_alu_commit_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_dst_a;
    logic [3:0]  in_dst_b;
    logic [19:0] in_res_a;
    logic [19:0] in_res_b;
    logic        in_zero;
    logic        in_sign;
    logic        in_carry;
    logic [2:0]  in_flag_mask;
    logic [1:0]  in_jcond;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic        wr_ack;
    logic [2:0]  status_q;
    logic        jmp_valid;
    logic [19:0] jmp_target;
    logic        trap_req;
    logic        trap_ret;

    int checks = 0;
    int errors = 0;

    alu_commit_stage #(.DATA_W(20), .REG_AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst_a(in_dst_a), .in_dst_b(in_dst_b), .in_res_a(in_res_a), .in_res_b(in_res_b),
        .in_zero(in_zero), .in_sign(in_sign), .in_carry(in_carry),
        .in_flag_mask(in_flag_mask), .in_jcond(in_jcond),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .status_q(status_q), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .trap_req(trap_req), .trap_ret(trap_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_op = 0; in_dst_a = 0; in_dst_b = 0; in_res_a = 0; in_res_b = 0;
        in_zero = 0; in_sign = 0; in_carry = 0; in_flag_mask = 0; in_jcond = 0;
        wr_ack = 0; trap_req = 0; trap_ret = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
    endtask

    task automatic send(input logic [2:0] op, input logic [19:0] ra);
        in_valid = 1; in_op = op; in_res_a = ra;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, status_q, jmp_valid, jmp_target} !== '0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b wr_en=%b addr=%h data=%h st=%b jv=%b jt=%h, want all 0",
                     in_ready, wr_en, wr_addr, wr_data, status_q, jmp_valid, jmp_target);
        end
        repeat (2) tick();
        rst_n = 1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_wr();
        int cnt;
        send(3'd0, 20'h0ABCD);
        in_dst_a = 4'd3; in_flag_mask = 3'b111; in_zero = 0; in_sign = 1; in_carry = 0;
        tick();
        idle_inputs();
        checks++;
        if (status_q !== 3'b010) begin errors++; $display("FAIL wr_status: got %b want 010", status_q); end
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (!wr_en) break;
            cnt++;
            checks++;
            if (wr_addr !== 4'd3 || wr_data !== 20'h0ABCD || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL wr_hold: got addr=%h data=%h rdy=%b want 3/0abcd/0", wr_addr, wr_data, in_ready);
            end
            wr_ack = (cnt == 3);
            tick();
        end
        wr_ack = 0;
        checks++;
        if (cnt != 3) begin errors++; $display("FAIL wr_cycles: got %0d want 3", cnt); end
        checks++;
        if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL wr_done: got rdy=%b wr_en=%b want 1/0", in_ready, wr_en);
        end
    endtask

    task automatic test_swap();
        send(3'd1, 20'h00005);
        in_dst_a = 4'd1; in_dst_b = 4'd2; in_res_b = 20'hFFFFF; wr_ack = 1;
        tick();
        in_valid = 0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd1 || wr_data !== 20'h00005) begin
            errors++; $display("FAIL swap_first: got en=%b addr=%h data=%h want 1/1/00005", wr_en, wr_addr, wr_data);
        end
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd2 || wr_data !== 20'hFFFFF) begin
            errors++; $display("FAIL swap_second: got en=%b addr=%h data=%h want 1/2/fffff", wr_en, wr_addr, wr_data);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL swap_idle: got en=%b rdy=%b want 0/1", wr_en, in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_jmp();
        send(3'd4, 20'h00001);
        tick();
        send(3'd3, 20'h00400);
        in_jcond = 2'd1;
        tick();
        in_valid = 0;
        checks++;
        if (jmp_valid !== 1'b1 || jmp_target !== 20'h00400) begin
            errors++; $display("FAIL jmp_taken: got jv=%b jt=%h want 1/00400", jmp_valid, jmp_target);
        end
        tick();
        checks++;
        if (jmp_valid !== 1'b0) begin errors++; $display("FAIL jmp_pulse_len: got %b want 0", jmp_valid); end
        send(3'd3, 20'h00400);
        in_jcond = 2'd2;
        tick();
        in_valid = 0;
        checks++;
        if (jmp_valid !== 1'b0 || status_q !== 3'b001) begin
            errors++; $display("FAIL jmp_untaken: got jv=%b st=%b want 0/001", jmp_valid, status_q);
        end
        idle_inputs();
    endtask

    task automatic test_lsr_xsr();
        send(3'd4, 20'h00006);
        in_flag_mask = 3'b000;
        tick();
        checks++;
        if (status_q !== 3'b110 || in_ready !== 1'b1) begin
            errors++; $display("FAIL lsr: got st=%b rdy=%b want 110/1", status_q, in_ready);
        end
        send(3'd5, 20'h00003);
        tick();
        in_valid = 0;
        checks++;
        if (status_q !== 3'b101) begin errors++; $display("FAIL xsr: got %b want 101", status_q); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_write();
        send(3'd1, 20'h00011);
        in_dst_a = 4'd7; in_dst_b = 4'd8; in_res_b = 20'h00022; in_flag_mask = 3'b111; in_carry = 1;
        tick();
        in_valid = 0;
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL midrst_pre: got wr_en=%b want 1", wr_en); end
        rst_n = 0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || status_q !== 3'b000) begin
            errors++; $display("FAIL midrst_async: got wr_en=%b st=%b want 0/000", wr_en, status_q);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        wr_ack = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (wr_en !== 1'b0) begin errors++; $display("FAIL midrst_no_wrb: cycle %0d got wr_en=%b want 0", c, wr_en); end
        end
        idle_inputs();
    endtask

    task automatic test_trap();
        logic [2:0] exp_st;
`ifdef COMMIT_TRAP_SHADOW_EN
        exp_st = 3'b011;
`else
        exp_st = 3'b000;
`endif
        send(3'd4, 20'h00003);
        tick();
        in_valid = 0; trap_req = 1;
        tick();
        trap_req = 0;
        send(3'd4, 20'h00000);
        tick();
        in_valid = 0;
        checks++;
        if (status_q !== 3'b000) begin errors++; $display("FAIL trap_lsr0: got %b want 000", status_q); end
        trap_ret = 1;
        tick();
        trap_ret = 0;
        checks++;
        if (status_q !== exp_st) begin errors++; $display("FAIL trap_ret: got %b want %b", status_q, exp_st); end
        idle_inputs();
    endtask

    task automatic test_random(input int n);
        logic [2:0]  m_status;
        logic [3:0]  qa[$];
        logic [19:0] qd[$];
        bit          m_jv;
        logic [19:0] m_jt;
        bit          taken;
        logic [2:0]  f;
        do_reset();
        m_status = 0; m_jv = 0; m_jt = 0;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (in_ready !== (qa.size() == 0) || wr_en !== (qa.size() != 0)) begin
                errors++; $display("FAIL rnd_ctrl[%0d]: got rdy=%b en=%b want rdy=%b", i, in_ready, wr_en, qa.size() == 0);
            end
            if (qa.size() != 0) begin
                checks++;
                if (wr_addr !== qa[0] || wr_data !== qd[0]) begin
                    errors++; $display("FAIL rnd_write[%0d]: got %h/%h want %h/%h", i, wr_addr, wr_data, qa[0], qd[0]);
                end
            end
            checks++;
            if (status_q !== m_status || jmp_valid !== m_jv) begin
                errors++; $display("FAIL rnd_status[%0d]: got st=%b jv=%b want %b/%b", i, status_q, jmp_valid, m_status, m_jv);
            end
            if (m_jv) begin
                checks++;
                if (jmp_target !== m_jt) begin errors++; $display("FAIL rnd_target[%0d]: got %h want %h", i, jmp_target, m_jt); end
            end
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = 3'($urandom_range(0, 7));
            in_dst_a = 4'($urandom); in_dst_b = 4'($urandom);
            in_res_a = 20'($urandom); in_res_b = 20'($urandom);
            in_zero = 1'($urandom); in_sign = 1'($urandom); in_carry = 1'($urandom);
            in_flag_mask = 3'($urandom); in_jcond = 2'($urandom);
            wr_ack = ($urandom_range(0, 2) != 0);
            m_jv = 0;
            if (qa.size() != 0) begin
                if (wr_ack) begin
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
            end else if (in_valid) begin
                f = {in_carry, in_sign, in_zero};
                case (in_op)
                    3'd0, 3'd1, 3'd2: begin
                        for (int b = 0; b < 3; b++)
                            if (in_flag_mask[b]) m_status[b] = f[b];
                        if (in_op != 3'd2) begin qa.push_back(in_dst_a); qd.push_back(in_res_a); end
                        if (in_op == 3'd1) begin qa.push_back(in_dst_b); qd.push_back(in_res_b); end
                    end
                    3'd3: begin
                        if (in_jcond == 0)      taken = 1;
                        else if (in_jcond == 1) taken = m_status[0];
                        else if (in_jcond == 2) taken = m_status[1];
                        else                    taken = m_status[0] || m_status[1];
                        if (taken) begin m_jv = 1; m_jt = in_res_a; end
                    end
                    3'd4: m_status = in_res_a[2:0];
                    3'd5: m_status = m_status ^ in_res_a[2:0];
                    default: ;
                endcase
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wr();
        test_swap();
        test_jmp();
        test_lsr_xsr();
        test_reset_mid_write();
        test_trap();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
